// File: rtl/sprite_scan_scheduler_if.sv
// Sprite scan scheduler bus: pixel strobe, sprite register bank read port,
// datapath hand-off and scan result / overrun status.
interface sprite_scan_scheduler_if #(
  parameter int unsigned SLOT_W = 3
);
  logic              is_pixel;
  logic [SLOT_W-1:0] reg_rd_addr;
  logic [31:0]       reg_rd_data;
  logic [31:0]       data_reg;
  logic              is_sprite;
  logic              scan_done;
  logic              hit_valid;
  logic [SLOT_W-1:0] hit_slot;
  logic [31:0]       hit_data;
  logic              clr_overrun;
  logic              overrun;

  // Scheduler side
  modport master (
    input  is_pixel, reg_rd_data, is_sprite, clr_overrun,
    output reg_rd_addr, data_reg, scan_done, hit_valid, hit_slot, hit_data, overrun
  );

  // Environment side: register bank, datapath and pixel timing
  modport slave (
    output is_pixel, reg_rd_data, is_sprite, clr_overrun,
    input  reg_rd_addr, data_reg, scan_done, hit_valid, hit_slot, hit_data, overrun
  );
endinterface

// File: rtl/sprite_scan_scheduler.sv
// Per-pixel sprite slot scanner. On each accepted is_pixel strobe the slots are
// read out of a synchronous-read register bank in ascending order; each word is
// shown to the address-calculation datapath through data_reg and the first slot
// that is enabled and reported as a sprite wins. A strobe arriving mid-scan
// restarts the scan from slot 0 and raises the sticky overrun flag.
module sprite_scan_scheduler #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_W    = 3,
  parameter int unsigned EN_BIT    = 31
) (
  input logic                     clk,
  input logic                     reset,
  sprite_scan_scheduler_if.master bus
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [SLOT_W-1:0] rd_addr, rd_addr_n;
  logic              chk_valid, chk_valid_n;
  logic [SLOT_W-1:0] chk_slot, chk_slot_n;
  logic              hit_valid, hit_valid_n;
  logic [SLOT_W-1:0] hit_slot, hit_slot_n;
  logic [31:0]       hit_data, hit_data_n;
  logic              overrun, overrun_n;
  logic              slot_hit;

  // The slot currently on reg_rd_data hits when it is enabled and the datapath agrees
  assign slot_hit = chk_valid & bus.reg_rd_data[EN_BIT] & bus.is_sprite;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      chk_valid <= 1'b0;
      chk_slot  <= '0;
      hit_valid <= 1'b0;
      hit_slot  <= '0;
      hit_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      rd_addr   <= rd_addr_n;
      chk_valid <= chk_valid_n;
      chk_slot  <= chk_slot_n;
      hit_valid <= hit_valid_n;
      hit_slot  <= hit_slot_n;
      hit_data  <= hit_data_n;
      overrun   <= overrun_n;
    end
  end

  // Next-state: scan sequencing, check pipeline, result capture and overrun
  always_comb begin
    state_n     = state;
    rd_addr_n   = rd_addr;
    chk_valid_n = chk_valid;
    chk_slot_n  = chk_slot;
    hit_valid_n = hit_valid;
    hit_slot_n  = hit_slot;
    hit_data_n  = hit_data;
    overrun_n   = overrun;

    // A mid-scan strobe below overrides this clear, so set wins on a collision
    if (bus.clr_overrun) begin
      overrun_n = 1'b0;
    end

    case (state)
      IDLE, DONE: begin
        chk_valid_n = 1'b0;
        if (bus.is_pixel) begin
          state_n     = SCAN;
          rd_addr_n   = '0;
          hit_valid_n = 1'b0;
          hit_slot_n  = '0;
          hit_data_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end

      SCAN: begin
        if (bus.is_pixel) begin
          // Abort: restart from slot 0 and drop whatever word is in flight
          rd_addr_n   = '0;
          chk_valid_n = 1'b0;
          hit_valid_n = 1'b0;
          hit_slot_n  = '0;
          hit_data_n  = '0;
          overrun_n   = 1'b1;
        end else if (slot_hit) begin
          // Slots are checked in ascending order, so the first hit is the lowest index
          state_n     = DONE;
          chk_valid_n = 1'b0;
          hit_valid_n = 1'b1;
          hit_slot_n  = chk_slot;
          hit_data_n  = bus.reg_rd_data;
        end else if (chk_valid && (chk_slot == LAST_SLOT)) begin
          state_n     = DONE;
          chk_valid_n = 1'b0;
        end else begin
          // The word requested now is on reg_rd_data next cycle
          chk_valid_n = 1'b1;
          chk_slot_n  = rd_addr;
          if (rd_addr != LAST_SLOT) begin
            rd_addr_n = rd_addr + SLOT_W'(1);
          end
        end
      end

      default: begin
        state_n     = IDLE;
        chk_valid_n = 1'b0;
      end
    endcase
  end

  assign bus.reg_rd_addr = rd_addr;
  assign bus.data_reg    = chk_valid ? bus.reg_rd_data : hit_data;
  assign bus.scan_done   = (state == DONE);
  assign bus.hit_valid   = hit_valid;
  assign bus.hit_slot    = hit_slot;
  assign bus.hit_data    = hit_data;
  assign bus.overrun     = overrun;

endmodule

// File: tb/tb_sprite_scan_scheduler.sv
// Self-checking bench for sprite_scan_scheduler: directed scenarios with literal
// expectations followed by randomized pixel strobes, all compared every cycle
// against a scan-level reference model.
module tb_sprite_scan_scheduler;

  localparam int NS = 8;

  logic clk;
  logic reset;
  logic force_spr;
  logic [31:0] mem [NS];

  int n_checks;
  int n_fail;

  sprite_scan_scheduler_if #(.SLOT_W(3)) sif ();

  sprite_scan_scheduler #(
    .NUM_SLOTS(NS),
    .SLOT_W(3),
    .EN_BIT(31)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read sprite register bank
  always @(posedge clk) sif.reg_rd_data <= mem[sif.reg_rd_addr];

  // Datapath stand-in: bit 30 of the presented word marks a sprite, or force all
  assign sif.is_sprite = force_spr | sif.data_reg[30];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (scan level) ----------------
  function automatic int first_hit();
    for (int s = 0; s < NS; s++)
      if (mem[s][31] && (force_spr || mem[s][30])) return s;
    return -1;
  endfunction

  logic        m_busy, m_done, m_found, m_hv, m_ovr;
  logic [2:0]  m_slot, m_hs;
  logic [31:0] m_hd;
  int          m_k;

  function automatic int scan_len(input logic found, input logic [2:0] slot);
    return found ? int'(slot) + 2 : NS + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_found <= 1'b0; m_slot <= '0;
      m_hv <= 1'b0; m_hs <= '0; m_hd <= '0; m_ovr <= 1'b0; m_k <= 0;
    end else begin
      if (sif.is_pixel && m_busy) m_ovr <= 1'b1;
      else if (sif.clr_overrun) m_ovr <= 1'b0;
      if (sif.is_pixel) begin
        m_busy  <= 1'b1;
        m_done  <= 1'b0;
        m_k     <= 0;
        m_found <= (first_hit() >= 0);
        m_slot  <= 3'(first_hit());
        m_hv <= 1'b0; m_hs <= '0; m_hd <= '0;
      end else if (m_busy) begin
        m_k <= m_k + 1;
        if (m_k + 1 == scan_len(m_found, m_slot)) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hv   <= m_found;
          m_hs   <= m_found ? m_slot : 3'd0;
          m_hd   <= m_found ? mem[m_slot] : 32'd0;
        end
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_scan_done", 32'(sif.scan_done), 32'd0);
      check("rst_addr", 32'(sif.reg_rd_addr), 32'd0);
      check("rst_hit_valid", 32'(sif.hit_valid), 32'd0);
      check("rst_data_reg", sif.data_reg, 32'd0);
      check("rst_overrun", 32'(sif.overrun), 32'd0);
    end else begin
      check("scan_done", 32'(sif.scan_done), 32'(m_done));
      check("hit_valid", 32'(sif.hit_valid), 32'(m_hv));
      check("hit_slot", 32'(sif.hit_slot), 32'(m_hs));
      check("hit_data", sif.hit_data, m_hd);
      check("overrun", 32'(sif.overrun), 32'(m_ovr));
      if (m_busy)
        check("reg_rd_addr", 32'(sif.reg_rd_addr), 32'((m_k < NS - 1) ? m_k : NS - 1));
      check("data_reg", sif.data_reg, (m_busy && m_k >= 1) ? mem[m_k - 1] : m_hd);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a negedge; returns at the negedge following E0
  task automatic pulse_pixel();
    sif.is_pixel = 1'b1;
    @(negedge clk);
    sif.is_pixel = 1'b0;
  endtask

  // Cycles from E0 until scan_done is seen; -1 if the budget runs out
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sif.scan_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int lat;
  int pulses;
  int first;

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; force_spr = 1'b0;
    sif.is_pixel = 1'b0; sif.clr_overrun = 1'b0;
    for (int s = 0; s < NS; s++) mem[s] = '0;

    @(negedge clk);
    check("reset_hit_slot", 32'(sif.hit_slot), 32'd0);
    check("reset_hit_data", sif.hit_data, 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    // Slots 2 and 5 enabled, everything a sprite: slot 2 wins at cycle 4
    force_spr = 1'b1;
    for (int s = 0; s < NS; s++) mem[s] = 32'h0A5A_0000 | 32'(s);
    mem[2] = 32'h8000_1202;
    mem[5] = 32'h8000_1505;
    pulse_pixel();
    wait_done(lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_hit_valid", 32'(sif.hit_valid), 32'd1);
    check("t1_hit_slot", 32'(sif.hit_slot), 32'd2);
    check("t1_hit_data", sif.hit_data, 32'h8000_1202);
    idle_cycles(2);
    check("t1_data_reg", sif.data_reg, 32'h8000_1202);

    // No slot enabled even though every word is a sprite: full-length miss
    for (int s = 0; s < NS; s++) mem[s] = 32'h4000_0000 | 32'(s);
    pulse_pixel();
    wait_done(lat);
    check("t2_latency", 32'(lat), 32'd9);
    check("t2_hit_valid", 32'(sif.hit_valid), 32'd0);
    check("t2_data_reg", sif.data_reg, 32'd0);
    idle_cycles(2);

    // Only slot 7 hits; the others are enabled but not sprites
    force_spr = 1'b0;
    for (int s = 0; s < NS; s++) mem[s] = 32'h8000_0000 | 32'(s);
    mem[7] = 32'hC000_0777;
    pulse_pixel();
    wait_done(lat);
    check("t3_latency", 32'(lat), 32'd9);
    check("t3_hit_slot", 32'(sif.hit_slot), 32'd7);
    check("t3_hit_data", sif.hit_data, 32'hC000_0777);
    idle_cycles(2);

    // Restart 3 cycles into a scan, colliding with clr_overrun (set wins)
    force_spr = 1'b1;
    for (int s = 0; s < NS; s++) mem[s] = 32'h0000_0100 | 32'(s);
    mem[4] = 32'h8000_0444;
    pulse_pixel();
    idle_cycles(2);
    sif.is_pixel = 1'b1;
    sif.clr_overrun = 1'b1;
    @(negedge clk);
    sif.is_pixel = 1'b0;
    sif.clr_overrun = 1'b0;
    check("t4_overrun_set", 32'(sif.overrun), 32'd1);
    check("t4_restart_addr", 32'(sif.reg_rd_addr), 32'd0);
    pulses = 0; first = -1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (sif.scan_done) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    check("t4_done_pulses", 32'(pulses), 32'd1);
    check("t4_latency", 32'(first), 32'd6);
    check("t4_hit_slot", 32'(sif.hit_slot), 32'd4);
    sif.clr_overrun = 1'b1;
    @(negedge clk);
    sif.clr_overrun = 1'b0;
    check("t4_overrun_clr", 32'(sif.overrun), 32'd0);

    // Strobe during DONE: back-to-back scans, result cleared at acceptance
    mem[4] = 32'h0000_0104;
    mem[1] = 32'h8000_0111;
    pulse_pixel();
    wait_done(lat);
    check("t5_latency_a", 32'(lat), 32'd3);
    pulse_pixel();
    check("t5_no_done", 32'(sif.scan_done), 32'd0);
    check("t5_hv_cleared", 32'(sif.hit_valid), 32'd0);
    check("t5_hd_cleared", sif.hit_data, 32'd0);
    wait_done(lat);
    check("t5_latency_b", 32'(lat), 32'd3);
    check("t5_hit_valid", 32'(sif.hit_valid), 32'd1);
    idle_cycles(2);

    // Reset mid-scan (with overrun set): immediate clear, no scan_done afterwards
    mem[1] = 32'h0000_0101;
    mem[6] = 32'h8000_0666;
    pulse_pixel();
    pulse_pixel();
    idle_cycles(3);
    #2 reset = 1'b0;
    #1;
    check("t6_async_done", 32'(sif.scan_done), 32'd0);
    check("t6_async_addr", 32'(sif.reg_rd_addr), 32'd0);
    check("t6_async_overrun", 32'(sif.overrun), 32'd0);
    check("t6_async_hv", 32'(sif.hit_valid), 32'd0);
    check("t6_async_hs", 32'(sif.hit_slot), 32'd0);
    check("t6_async_hd", sif.hit_data, 32'd0);
    check("t6_async_data_reg", sif.data_reg, 32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (sif.scan_done) pulses++;
    end
    check("t6_no_done", 32'(pulses), 32'd0);

    // Randomized strobes, clears and slot contents against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!m_busy && !m_done && ($urandom_range(0, 3) == 0)) begin
        force_spr = ($urandom_range(0, 3) == 0);
        for (int s = 0; s < NS; s++) begin
          mem[s] = $urandom;
          mem[s][31] = ($urandom_range(0, 2) == 0);
        end
      end
      if (m_busy) sif.is_pixel = ($urandom_range(0, 15) == 0);
      else        sif.is_pixel = ($urandom_range(0, 3) == 0);
      sif.clr_overrun = ($urandom_range(0, 15) == 0);
    end
    sif.is_pixel = 1'b0;
    sif.clr_overrun = 1'b0;
    idle_cycles(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
